// File: rtl/program_loader.sv
// program_loader: writes a UART byte stream into instruction memory until an aligned HALT word or memory full
module program_loader #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_INSTRUCTION_ADDRESS = 7,
  parameter logic [NB_DATA-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [NB_BYTE-1:0]                i_rx_byte,
  input  logic                              i_rx_valid,
  output logic [NB_BYTE-1:0]                o_load_program_byte,
  output logic                              o_load_program_write_enable,
  output logic                              o_pc_reset,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_overflow_error,
  output logic [NB_INSTRUCTION_ADDRESS:0]   o_byte_count,
  output logic [NB_INSTRUCTION_ADDRESS-2:0] o_instruction_count
);
  localparam int NB_IDX = $clog2(NB_DATA / NB_BYTE);
  typedef enum logic [2:0] {IDLE, CLEAR, RECEIVE, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [NB_DATA-1:0] word, word_n, assembled;
  logic [NB_IDX-1:0] idx, idx_n;
  logic [NB_BYTE-1:0] byte_n;
  logic we_n, pcr_n, busy_n, done_n, ovf_n;
  logic [NB_INSTRUCTION_ADDRESS:0] bc_n;
  logic [NB_INSTRUCTION_ADDRESS-2:0] ic_n;
  assign assembled = {word[NB_DATA-NB_BYTE-1:0], i_rx_byte};
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      word <= '0;
      idx <= '0;
      o_load_program_byte <= '0;
      o_load_program_write_enable <= 1'b0;
      o_pc_reset <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_overflow_error <= 1'b0;
      o_byte_count <= '0;
      o_instruction_count <= '0;
    end else begin
      state <= state_n;
      word <= word_n;
      idx <= idx_n;
      o_load_program_byte <= byte_n;
      o_load_program_write_enable <= we_n;
      o_pc_reset <= pcr_n;
      o_busy <= busy_n;
      o_done <= done_n;
      o_overflow_error <= ovf_n;
      o_byte_count <= bc_n;
      o_instruction_count <= ic_n;
    end
  end
  // Outputs are computed for the state being entered, so they line up with it after the clock
  always_comb begin
    state_n = state;
    word_n = word;
    idx_n = idx;
    byte_n = o_load_program_byte;
    we_n = 1'b0;
    pcr_n = 1'b0;
    busy_n = 1'b0;
    done_n = o_done;
    ovf_n = o_overflow_error;
    bc_n = o_byte_count;
    ic_n = o_instruction_count;
    case (state)
      CLEAR: begin
        state_n = RECEIVE;
        busy_n = 1'b1;
      end
      RECEIVE: begin
        busy_n = 1'b1;
        if (i_rx_valid && o_byte_count[NB_INSTRUCTION_ADDRESS]) begin
          state_n = ERROR;
          ovf_n = 1'b1;
          busy_n = 1'b0;
        end else if (i_rx_valid) begin
          byte_n = i_rx_byte;
          we_n = 1'b1;
          word_n = assembled;
          bc_n = o_byte_count + 1'b1;
          idx_n = idx + 1'b1;
          if (&idx) begin
            ic_n = o_instruction_count + 1'b1;
            if (assembled == HALT_INSTRUCTION) begin
              state_n = DONE;
              done_n = 1'b1;
              busy_n = 1'b0;
            end
          end
        end
      end
      default: if (i_start) begin
        state_n = CLEAR;
        pcr_n = 1'b1;
        busy_n = 1'b1;
        word_n = '0;
        idx_n = '0;
        bc_n = '0;
        ic_n = '0;
        done_n = 1'b0;
        ovf_n = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed load sessions checked against hand-computed expectations
module tb_program_loader;
  logic i_clock = 1'b0;
  logic i_reset, i_start, i_rx_valid;
  logic [7:0] i_rx_byte;
  logic [7:0] o_load_program_byte;
  logic o_load_program_write_enable, o_pc_reset, o_busy, o_done, o_overflow_error;
  logic [7:0] o_byte_count;
  logic [5:0] o_instruction_count;
  int total = 0;
  int bad = 0;

  program_loader dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_rx_byte(i_rx_byte),
    .i_rx_valid(i_rx_valid),
    .o_load_program_byte(o_load_program_byte),
    .o_load_program_write_enable(o_load_program_write_enable),
    .o_pc_reset(o_pc_reset),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_overflow_error(o_overflow_error),
    .o_byte_count(o_byte_count),
    .o_instruction_count(o_instruction_count)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " byte"}, 32'(o_load_program_byte), 0);
    chk({tag, " we"}, 32'(o_load_program_write_enable), 0);
    chk({tag, " pcr"}, 32'(o_pc_reset), 0);
    chk({tag, " busy"}, 32'(o_busy), 0);
    chk({tag, " done"}, 32'(o_done), 0);
    chk({tag, " ovf"}, 32'(o_overflow_error), 0);
    chk({tag, " bc"}, 32'(o_byte_count), 0);
    chk({tag, " ic"}, 32'(o_instruction_count), 0);
  endtask

  task automatic send(input logic [7:0] b, input logic exp_done);
    i_rx_byte = b;
    i_rx_valid = 1'b1;
    tick;
    i_rx_valid = 1'b0;
    chk("strobe", 32'(o_load_program_write_enable), 1);
    chk("wbyte", 32'(o_load_program_byte), 32'(b));
    chk("done", 32'(o_done), 32'(exp_done));
  endtask

  task automatic start_session;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("clr pcr", 32'(o_pc_reset), 1);
    chk("clr busy", 32'(o_busy), 1);
    chk("clr done", 32'(o_done), 0);
    chk("clr ovf", 32'(o_overflow_error), 0);
    chk("clr bc", 32'(o_byte_count), 0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_byte = 8'h00;
    tick;
    tick;
    chk_all_zero("reset");
    i_reset = 1'b0;
    i_rx_byte = 8'hAB;
    i_rx_valid = 1'b1;
    tick;
    i_rx_valid = 1'b0;
    chk("idle we", 32'(o_load_program_write_enable), 0);
    chk("idle bc", 32'(o_byte_count), 0);

    start_session;
    tick;
    chk("rx pcr", 32'(o_pc_reset), 0);
    chk("rx busy", 32'(o_busy), 1);
    send(8'h20, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h05, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 1);
    chk("norm bc", 32'(o_byte_count), 8);
    chk("norm ic", 32'(o_instruction_count), 2);
    chk("norm busy", 32'(o_busy), 0);
    tick;
    chk("norm we off", 32'(o_load_program_write_enable), 0);
    chk("norm done held", 32'(o_done), 1);

    start_session;
    i_rx_byte = 8'h11;
    i_rx_valid = 1'b1;
    tick;
    i_rx_valid = 1'b0;
    chk("clear drop we", 32'(o_load_program_write_enable), 0);
    chk("clear drop bc", 32'(o_byte_count), 0);
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    chk("unal busy5", 32'(o_busy), 1);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 1);
    chk("unal ic", 32'(o_instruction_count), 3);
    chk("unal bc", 32'(o_byte_count), 12);

    start_session;
    tick;
    for (int i = 0; i < 128; i++) send(8'h00, 0);
    chk("ovf bc128", 32'(o_byte_count), 128);
    chk("ovf ic32", 32'(o_instruction_count), 32);
    i_rx_byte = 8'h77;
    i_rx_valid = 1'b1;
    tick;
    i_rx_valid = 1'b0;
    chk("ovf no129", 32'(o_load_program_write_enable), 0);
    chk("ovf flag", 32'(o_overflow_error), 1);
    chk("ovf done", 32'(o_done), 0);
    chk("ovf busy", 32'(o_busy), 0);
    chk("ovf bc", 32'(o_byte_count), 128);

    start_session;
    tick;
    for (int i = 0; i < 124; i++) send(8'h00, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 1);
    chk("fill ovf", 32'(o_overflow_error), 0);
    chk("fill bc", 32'(o_byte_count), 128);
    chk("fill ic", 32'(o_instruction_count), 32);
    tick;
    chk("fill done held", 32'(o_done), 1);

    start_session;
    tick;
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("ign pcr", 32'(o_pc_reset), 0);
    chk("ign busy", 32'(o_busy), 1);
    chk("ign we", 32'(o_load_program_write_enable), 0);
    send(8'h04, 0);
    send(8'h05, 0);
    chk("mid bc", 32'(o_byte_count), 5);
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
    chk_all_zero("midrst");
    i_rx_byte = 8'hFF;
    i_rx_valid = 1'b1;
    tick;
    i_rx_valid = 1'b0;
    chk("midrst idle we", 32'(o_load_program_write_enable), 0);
    start_session;
    tick;
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 1);
    chk("restart bc", 32'(o_byte_count), 4);
    chk("restart ic", 32'(o_instruction_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
